// File: rtl/debounced_in_port_if.sv
// Load/store bus between the core and the debounced input peripheral.
// The core drives address and store data; the peripheral answers with read data, hit and irq.
interface debounced_in_port_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  modport master (output addr, output we, output wdata, input rdata, input hit, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output hit, output irq);
endinterface

// File: rtl/debounced_in_port.sv
// Memory-mapped input port: per-pin synchroniser and debouncer, sticky W1C edge flags
// and a maskable level interrupt.
module debounced_in_port #(
  parameter int          BITS_PORT       = 3,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_BITS        = 16,
  parameter logic [31:0] ADDR_DATA       = 32'h00000101,
  parameter logic [31:0] ADDR_EDGE       = 32'h00000103,
  parameter logic [31:0] ADDR_MASK       = 32'h00000104
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BITS_PORT-1:0] pins,
  debounced_in_port_if.slave   bus
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [BITS_PORT-1:0] sync1_reg, sync2_reg;
  logic [BITS_PORT-1:0] stable_vec, accept_vec;
  logic [BITS_PORT-1:0] rise_reg, rise_next, fall_reg, fall_next;
  logic [BITS_PORT-1:0] rise_mask_reg, rise_mask_next, fall_mask_reg, fall_mask_next;
  logic [BITS_PORT-1:0] rise_clr, fall_clr;
  logic                 edge_wr, mask_wr;
  logic [31:0]          rd_data;
  logic                 rd_hit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pins;
      sync2_reg <= sync1_reg;
    end
  end

  // A disagreeing level must persist DEBOUNCE_CYCLES edges in a row; any agreement restarts the count.
  generate
    for (genvar gi = 0; gi < BITS_PORT; gi++) begin : pin_g
      logic [CNT_BITS-1:0] cnt_reg, cnt_next;
      logic                stable_reg, stable_next;
      logic                accept;

      always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        accept      = 1'b0;
        if (sync2_reg[gi] == stable_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          accept      = 1'b1;
          stable_next = sync2_reg[gi];
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
        end
      end

      assign stable_vec[gi] = stable_reg;
      assign accept_vec[gi] = accept;
    end
  endgenerate

  assign edge_wr = bus.we && (bus.addr == ADDR_EDGE);
  assign mask_wr = bus.we && (bus.addr == ADDR_MASK);

  // Clear is applied before the set so a new edge on the same cycle survives the write.
  always_comb begin
    rise_clr       = '0;
    fall_clr       = '0;
    rise_mask_next = rise_mask_reg;
    fall_mask_next = fall_mask_reg;
    if (edge_wr) begin
      rise_clr = bus.wdata[BITS_PORT-1:0];
      fall_clr = bus.wdata[16 +: BITS_PORT];
    end
    if (mask_wr) begin
      rise_mask_next = bus.wdata[BITS_PORT-1:0];
      fall_mask_next = bus.wdata[16 +: BITS_PORT];
    end
    rise_next = (rise_reg & ~rise_clr) | (accept_vec & sync2_reg);
    fall_next = (fall_reg & ~fall_clr) | (accept_vec & ~sync2_reg);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rise_reg      <= '0;
      fall_reg      <= '0;
      rise_mask_reg <= '0;
      fall_mask_reg <= '0;
    end else begin
      rise_reg      <= rise_next;
      fall_reg      <= fall_next;
      rise_mask_reg <= rise_mask_next;
      fall_mask_reg <= fall_mask_next;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (bus.addr == ADDR_DATA) begin
      rd_hit                   = 1'b1;
      rd_data[BITS_PORT-1:0]   = stable_vec;
    end else if (bus.addr == ADDR_EDGE) begin
      rd_hit                   = 1'b1;
      rd_data[BITS_PORT-1:0]   = rise_reg;
      rd_data[16 +: BITS_PORT] = fall_reg;
    end else if (bus.addr == ADDR_MASK) begin
      rd_hit                   = 1'b1;
      rd_data[BITS_PORT-1:0]   = rise_mask_reg;
      rd_data[16 +: BITS_PORT] = fall_mask_reg;
    end
  end

  assign bus.rdata = rd_data;
  assign bus.hit   = rd_hit;
  assign bus.irq   = |((rise_reg & rise_mask_reg) | (fall_reg & fall_mask_reg));

endmodule

// File: tb/tb_debounced_in_port.sv
// Randomised and directed bench for debounced_in_port against a sliding-window reference model.
module tb_debounced_in_port;
  localparam int          DC     = 4;
  localparam logic [31:0] A_DATA = 32'h00000101;
  localparam logic [31:0] A_EDGE = 32'h00000103;
  localparam logic [31:0] A_MASK = 32'h00000104;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] pins = 3'b000;

  debounced_in_port_if bus ();

  debounced_in_port #(
    .BITS_PORT(3), .DEBOUNCE_CYCLES(DC), .CNT_BITS(16),
    .ADDR_DATA(A_DATA), .ADDR_EDGE(A_EDGE), .ADDR_MASK(A_MASK)
  ) dut (
    .CLK(CLK), .RST(RST), .pins(pins), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a level is accepted once the last DC synchronised samples all disagree with it.
  logic [2:0] m_stable, m_rise, m_fall, m_rmask, m_fmask;
  logic [2:0] hist[$];

  function automatic void model_reset();
    m_stable = '0; m_rise = '0; m_fall = '0; m_rmask = '0; m_fmask = '0;
    hist.delete();
    for (int i = 0; i < DC + 2; i++) hist.push_back(3'b000);
  endfunction

  function automatic void model_edge();
    logic [2:0] flip;
    logic [2:0] rset;
    logic [2:0] fset;
    logic       diff;
    if (RST) begin
      model_reset();
      return;
    end
    flip = '0;
    hist.push_back(pins);
    if (hist.size() > DC + 2) void'(hist.pop_front());
    for (int i = 0; i < 3; i++) begin
      diff = 1'b1;
      for (int k = 0; k < DC; k++)
        if (hist[k][i] == m_stable[i]) diff = 1'b0;
      flip[i] = diff;
    end
    rset = flip & ~m_stable;
    fset = flip & m_stable;
    if (bus.we && bus.addr == A_EDGE) begin
      m_rise = m_rise & ~bus.wdata[2:0];
      m_fall = m_fall & ~bus.wdata[18:16];
    end
    if (bus.we && bus.addr == A_MASK) begin
      m_rmask = bus.wdata[2:0];
      m_fmask = bus.wdata[18:16];
    end
    m_rise   = m_rise | rset;
    m_fall   = m_fall | fset;
    m_stable = m_stable ^ flip;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a == A_DATA) r[2:0] = m_stable;
    else if (a == A_EDGE) begin r[2:0] = m_rise; r[18:16] = m_fall; end
    else if (a == A_MASK) begin r[2:0] = m_rmask; r[18:16] = m_fmask; end
    return r;
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
    return (a == A_DATA) || (a == A_EDGE) || (a == A_MASK);
  endfunction

  function automatic logic exp_irq();
    return |((m_rise & m_rmask) | (m_fall & m_fmask));
  endfunction

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b0;
    #1;
    d = bus.rdata;
    $display("rd   addr=%h data=%h hit=%b irq=%b", a, d, bus.hit, bus.irq);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    $display("wr   addr=%h data=%h", a, d);
    step();
    bus.we = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] p);
    pins = p;
    RST  = 1'b1;
    model_reset();
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [3];
    addrs = '{A_DATA, A_EDGE, A_MASK};
    pins = 3'b111;
    RST  = 1'b1;
    model_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i], d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_rdata addr=%h got=%h exp=%h", addrs[i], d, 32'h0); end
      checks++;
      if (bus.hit !== 1'b1) begin errors++; $display("FAIL reset_hit addr=%h got=%b exp=1", addrs[i], bus.hit); end
    end
    rd(32'h100, d);
    checks++;
    if (bus.hit !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL miss_addr got hit=%b data=%h exp hit=0 data=0", bus.hit, d); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    RST = 1'b0;
    for (int s = 1; s <= DC + 2; s++) begin
      step();
      rd(A_DATA, d);
      checks++;
      if (d !== ((s >= DC + 2) ? 32'h7 : 32'h0)) begin
        errors++; $display("FAIL post_reset_data step=%0d got=%h exp=%h", s, d, (s >= DC + 2) ? 32'h7 : 32'h0);
      end
    end
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL post_reset_rise got=%h exp=%h", d, 32'h7); end
  endtask

  task automatic test_clean_press();
    logic [31:0] d;
    do_reset(3'b000);
    step();
    pins = 3'b001;
    for (int s = 1; s <= DC + 2; s++) begin
      step();
      rd(A_DATA, d);
      checks++;
      if (d !== ((s >= DC + 2) ? 32'h1 : 32'h0)) begin
        errors++; $display("FAIL press_data step=%0d got=%h exp=%h", s, d, (s >= DC + 2) ? 32'h1 : 32'h0);
      end
    end
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL press_edge got=%h exp=%h", d, 32'h1); end
    wr(A_DATA, 32'hFFFF_FFFF);
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL data_write_ignored got=%h exp=%h", d, 32'h1); end
    pins = 3'b000;
    repeat (DC + 2) step();
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h00010001) begin errors++; $display("FAIL release_edge got=%h exp=%h", d, 32'h00010001); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    wr(A_EDGE, 32'h1);
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h00010000) begin errors++; $display("FAIL w1c_rise got=%h exp=%h", d, 32'h00010000); end
    wr(A_EDGE, 32'h00010000);
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_fall got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    do_reset(3'b000);
    pins = 3'b010;
    repeat (DC - 1) step();
    pins = 3'b000;
    for (int s = 0; s < 8; s++) begin
      step();
      rd(A_DATA, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL glitch_data step=%0d got=%h exp=%h", s, d, 32'h0); end
    end
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge got=%h exp=%h", d, 32'h0); end
    pins = 3'b010;
    repeat (DC) step();
    pins = 3'b000;
    step();
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL pulse_early got=%h exp=%h", d, 32'h0); end
    step();
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL pulse_accept got=%h exp=%h", d, 32'h2); end
    repeat (8) step();
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h00020002) begin errors++; $display("FAIL pulse_edge got=%h exp=%h", d, 32'h00020002); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    do_reset(3'b000);
    pins = 3'b100;
    repeat (DC + 1) step();
    wr(A_EDGE, 32'h4);
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL set_wins got=%h exp=%h", d, 32'h4); end
    wr(A_EDGE, 32'h4);
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clear_after got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    do_reset(3'b000);
    wr(A_MASK, 32'h1);
    rd(A_MASK, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL mask_rb got=%h exp=%h", d, 32'h1); end
    pins = 3'b001;
    for (int s = 1; s <= DC + 2; s++) begin
      step();
      checks++;
      if (bus.irq !== (s >= DC + 2)) begin errors++; $display("FAIL irq_rise step=%0d got=%b exp=%b", s, bus.irq, s >= DC + 2); end
    end
    wr(A_EDGE, 32'h1);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", bus.irq); end
    pins = 3'b000;
    repeat (DC + 2) step();
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h00010000 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL irq_fall_masked got edge=%h irq=%b exp edge=%h irq=0", d, bus.irq, 32'h00010000);
    end
    wr(A_MASK, 32'h00010000);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_fall_unmasked got=%b exp=1", bus.irq); end
    wr(A_MASK, 32'h0);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_mask_off got=%b exp=0", bus.irq); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset(3'b000);
    wr(A_MASK, 32'h00070007);
    pins = 3'b001;
    repeat (DC + 2) step();
    pins = 3'b101;
    repeat (4) step();
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h1 || bus.irq !== 1'b1) begin errors++; $display("FAIL pre_async got edge=%h irq=%b exp edge=%h irq=1", d, bus.irq, 32'h1); end
    #1;
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL async_irq got=%b exp=0", bus.irq); end
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_data got=%h exp=%h", d, 32'h0); end
    rd(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_edge got=%h exp=%h", d, 32'h0); end
    rd(A_MASK, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_mask got=%h exp=%h", d, 32'h0); end
    step();
    RST = 1'b0;
    repeat (DC + 1) step();
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rerelease_early got=%h exp=%h", d, 32'h0); end
    step();
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL rerelease_data got=%h exp=%h", d, 32'h5); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset(3'b000);
    for (int n = 0; n < 600; n++) begin
      RST = 1'b0;
      if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, 2)] = ~pins[$urandom_range(0, 2)];
      case ($urandom_range(0, 5))
        0: a = A_DATA;
        1: a = A_EDGE;
        2: a = A_MASK;
        3: a = 32'h00000100;
        4: a = 32'h00000102;
        default: a = $urandom;
      endcase
      bus.addr  = a;
      bus.wdata = $urandom;
      bus.we    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        RST = 1'b1;
        model_reset();
      end
      #1;
      $display("cyc %0d addr=%h we=%b wdata=%h pins=%b rst=%b rdata=%h hit=%b irq=%b",
               n, a, bus.we, bus.wdata, pins, RST, bus.rdata, bus.hit, bus.irq);
      checks++;
      if (bus.rdata !== exp_rd(a)) begin errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", n, bus.rdata, exp_rd(a)); end
      checks++;
      if (bus.hit !== exp_hit(a)) begin errors++; $display("FAIL rand_hit cyc=%0d got=%b exp=%b", n, bus.hit, exp_hit(a)); end
      checks++;
      if (bus.irq !== exp_irq()) begin errors++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", n, bus.irq, exp_irq()); end
      step();
    end
    bus.we = 1'b0;
    RST    = 1'b0;
  endtask

  initial begin
    bus.addr  = 32'h0;
    bus.we    = 1'b0;
    bus.wdata = 32'h0;
    model_reset();
    test_reset();
    test_clean_press();
    test_w1c();
    test_glitch();
    test_collision();
    test_irq();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
